alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 A  input  WIDTH  operand A, unsigned.
REQ-007 B  input  WIDTH  operand B, unsigned.
REQ-008 opcode  input  4  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ALU_out  output  2*WIDTH  registered result.
REQ-012 flag  output  3  registered; [0] carry/borrow/shifted-out bit, [1] A>B, [2] result zero.

Function
REQ-013 SHALL implement states IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE with rst low.
REQ-014 Accept SHALL occur when in_valid && in_ready; A, B and opcode SHALL be captured on that edge; inputs are ignored at all other times.
REQ-015 Non-MUL opcode: IDLE->DONE on accept; ALU_out/flag SHALL be loaded on the same edge, so out_valid rises the cycle after accept (latency 1).
REQ-016 MUL (4'b1010): IDLE->MUL on accept; one shift-add step per cycle for WIDTH cycles using a log2-sized iteration counter; MUL->DONE after step WIDTH, so out_valid rises WIDTH+1 cycles after accept.
REQ-017 DONE: out_valid=1; ALU_out and flag SHALL hold stable until out_valid && out_ready, then DONE->IDLE; no accept is possible in the handshake cycle (min. 2 cycles per operation).
REQ-018 Results, zero-extended to 2*WIDTH: 0001 ADD A+B (WIDTH+1 bits), flag[0]=sum bit WIDTH; 0010 SUB A-B modulo 2^(WIDTH+1), flag[0]=1 iff A<B.
REQ-019 0011 AND, 0100 OR, 0111 XOR, 1000 NOT (~A, WIDTH bits): flag[0]=0.
REQ-020 0101 SHL: A<<1 in WIDTH+1 bits, flag[0]=A[WIDTH-1]; 0110 SHR: A>>1 logical, flag[0]=A[0].
REQ-021 1010 MUL: full 2*WIDTH-bit unsigned product, flag[0]=0.
REQ-022 1001 CMP: ALU_out=0, flag[0]=0, flag[1]=(A>B); flag[1] SHALL change only on CMP completion and otherwise hold its previous value.
REQ-023 Undefined opcodes (0000, 1011-1111): ALU_out=0, flag[0]=0, latency 1.
REQ-024 flag[2] SHALL equal (ALU_out==0) for every completed operation, including CMP and undefined opcodes.
REQ-025 Outputs SHALL change only on entry to DONE or on reset; the MUL partial product SHALL be held in internal registers, not on ALU_out.

Reset
REQ-026 rst high SHALL force state IDLE, ALU_out=0, flag=3'b000, out_valid=0, iteration counter 0, and in_ready=0 while rst is high.
REQ-027 rst asserted in MUL or DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst SHALL take priority over simultaneous accept or output handshake.

Verification (WIDTH=8)
REQ-029 ADD A=0xFF B=0x01 -> one cycle after accept: out_valid=1, ALU_out=0x0100, flag=3'b001.
REQ-030 SUB A=0x05 B=0x07 -> ALU_out=0x01FE, flag[0]=1, flag[2]=0; SUB 0x07-0x07 -> ALU_out=0, flag=3'b100 (flag[1] unchanged).
REQ-031 MUL A=0xFF B=0xFF -> in_ready=0 for 9 cycles after accept, out_valid rises 9 cycles after accept, ALU_out=0xFE01, flag=3'b000.
REQ-032 ADD 0x10+0x20 with out_ready=0 for 3 cycles -> ALU_out=0x0030 and out_valid held stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> next cycle IDLE.
REQ-033 CMP A=0x80 B=0x7F -> flag=3'b110; then AND 0x0F&0xF0 -> ALU_out=0, flag=3'b110 (greater held).
REQ-034 MUL 0x12*0x34 with rst pulsed during 4th MUL cycle -> no out_valid, outputs 0, in_ready=1 after rst falls; next ADD 0x01+0x01 -> ALU_out=0x0002.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus a WIDTH-step shift-add multiplier,
// with valid/ready handshakes on both sides.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   ALU_out,
    output logic [2:0]           flag
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            mul_last;
    logic [CW-1:0]   cnt;
    logic [W2-1:0]   acc;
    logic [W2-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [W2-1:0]   prod_nxt;
    logic [W2-1:0]   res;
    logic            res_c;
    logic [WIDTH:0]  diff;
    logic [WIDTH-1:0] not_a;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (state == MUL) && (cnt == CW'(WIDTH - 1));
    assign prod_nxt  = acc + (mplier[0] ? mcand : '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (opcode == OP_MUL) ? MUL : DONE;
            MUL:  if (mul_last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result and carry/borrow/shifted-out bit
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        diff  = {1'b0, A} - {1'b0, B};
        not_a = ~A;
        case (opcode)
            OP_ADD: begin
                res   = W2'(A) + W2'(B);
                res_c = res[WIDTH];
            end
            OP_SUB: begin
                res   = W2'(diff);
                res_c = (A < B);
            end
            OP_AND: res = W2'(A & B);
            OP_OR:  res = W2'(A | B);
            OP_XOR: res = W2'(A ^ B);
            OP_NOT: res = W2'(not_a);
            OP_SHL: begin
                res   = W2'({A, 1'b0});
                res_c = A[WIDTH-1];
            end
            OP_SHR: begin
                res   = W2'(A >> 1);
                res_c = A[0];
            end
            default: begin
                res   = '0;
                res_c = 1'b0;
            end
        endcase
    end

    // Datapath: outputs load only on entry to DONE; partial product stays internal
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_out <= '0;
            flag    <= 3'b000;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (opcode == OP_MUL) begin
                mcand  <= W2'(A);
                mplier <= B;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                ALU_out <= res;
                flag    <= {(res == '0), ((opcode == OP_CMP) ? (A > B) : flag[1]), res_c};
            end
        end else if (state == MUL) begin
            acc    <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (mul_last) begin
                ALU_out <= prod_nxt;
                flag    <= {(prod_nxt == '0), flag[1], 1'b0};
                cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed bench for alu_multicycle (WIDTH=8) against an arithmetic
// reference model.
module tb_alu_multicycle;

    localparam int unsigned WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [3:0]         opcode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] ALU_out;
    logic [2:0]         flag;

    int errors = 0;
    int checks = 0;
    int gt_m   = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_out(ALU_out), .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation: accept, latency, result, optional back-pressure, release
    task automatic run_op(input int a, input int b, input int op, input int stall);
        int exp_out, exp_c, exp_lat, cycles;
        logic [2:0]  exp_flag;
        logic [15:0] held;
        exp_c = 0;
        case (op)
            1:  begin exp_out = a + b; exp_c = (exp_out >> 8) & 1; end
            2:  begin exp_out = (a - b) & 'h1FF; exp_c = (a < b) ? 1 : 0; end
            3:  exp_out = a & b;
            4:  exp_out = a | b;
            7:  exp_out = a ^ b;
            8:  exp_out = (~a) & 'hFF;
            5:  begin exp_out = (a << 1) & 'h1FF; exp_c = (a >> 7) & 1; end
            6:  begin exp_out = a >> 1; exp_c = a & 1; end
            10: exp_out = a * b;
            9:  begin exp_out = 0; gt_m = (a > b) ? 1 : 0; end
            default: exp_out = 0;
        endcase
        exp_lat  = (op == 10) ? 9 : 1;
        exp_flag = {(exp_out == 0), gt_m[0], exp_c[0]};

        @(negedge clk);
        check("idle_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        A = 8'(a);
        B = 8'(b);
        opcode = 4'(op);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        opcode = 4'($urandom);
        cycles = 1;
        while (!out_valid && cycles < 40) begin
            check("busy_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
            cycles++;
        end
        check("latency", 64'(cycles), 64'(exp_lat));
        check("done_ready", 64'(in_ready), 64'(0));
        check("result", 64'(ALU_out), 64'(exp_out));
        check("flag", 64'(flag), 64'(exp_flag));
        held = ALU_out;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_result", 64'(ALU_out), 64'(held));
            check("stall_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'(0));
        check("release_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        opcode = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_out", 64'(ALU_out), 64'(0));
        check("rst_flag", 64'(flag), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'(1));

        run_op('hFF, 'h01, 1, 0);
        run_op('h05, 'h07, 2, 0);
        run_op('h07, 'h07, 2, 0);
        run_op('hFF, 'hFF, 10, 0);
        run_op('h10, 'h20, 1, 3);
        run_op('h80, 'h7F, 9, 0);
        run_op('h0F, 'hF0, 3, 0);
        run_op('hA5, 'h00, 5, 1);
        run_op('h81, 'h00, 6, 0);
        run_op('h33, 'h44, 13, 0);

        // Abort a multiply with reset in its fourth busy cycle
        @(negedge clk);
        in_valid = 1'b1;
        A = 8'h12;
        B = 8'h34;
        opcode = 4'b1010;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'(in_ready), 64'(0));
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_out", 64'(ALU_out), 64'(0));
        check("abort_flag", 64'(flag), 64'(0));
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        gt_m = 0;
        @(negedge clk);
        check("abort_rel_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'(0));
        end
        run_op('h01, 'h01, 1, 0);

        for (int n = 0; n < 60; n++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
